uart_rx: RTL and testbench

- 8N1 UART receiver, counterpart to the team's transmitter.
- Samples the serial line using the shared 16x-oversampling `b_tick` from `baud_tick` (9600 baud at 100 MHz by default).
- Reassembles LSB-first bytes and presents each one with a single-cycle `rx_done` strobe and a framing-error flag.
- Sits between the board RX pin and downstream consumers: loopback to the transmitter, FIFO, command decoder.

---
 rtl/uart_rx.sv | 119 +++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop sampling, LSB-first reassembly,
// single-cycle done strobe with a framing-error flag.
module uart_rx #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int unsigned TickW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BitW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TickW-1:0]       tick_q, tick_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   done_d, busy_d, err_d;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  // State register; synchronizer resets high so the line reads idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '1;
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_STAGES'(rx);
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rx_data   <= data_d;
      rx_done   <= done_d;
      rx_busy   <= busy_d;
      frame_err <= err_d;
    end
  end

  // Next-state and datapath counters.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      StIdle: begin
        tick_d = '0;
        bit_d  = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (b_tick) begin
          if (tick_q == TickMid) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? StIdle : StData;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      StData: begin
        if (b_tick) begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_q == BitLast) state_d = StStop;
            else                  bit_d   = bit_q + BitW'(1);
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      StStop: begin
        if (b_tick) begin
          if (tick_q == TickLast) begin
            tick_d  = '0;
            state_d = StIdle;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered-output next values; data updates even on a framing error.
  always_comb begin
    done_d = (state_q == StStop) && b_tick && (tick_q == TickLast);
    data_d = done_d ? shift_q : rx_data;
    err_d  = done_d ? ~rx_s : frame_err;
    busy_d = (state_d != StIdle);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx using a fast b_tick divider to keep frames short.
module tb_uart_rx;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_busy, frame_err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_done_t = 0;
  int prev_done_t = 0;
  logic done_prev = 1'b0;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .b_tick   (b_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_busy  (rx_busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      b_tick = (cnt == TICK_DIV - 1);
      cnt = (cnt == TICK_DIV - 1) ? 0 : cnt + 1;
    end
  end

  // Done-pulse monitor: counts strobes and flags adjacent-cycle strobes.
  always @(negedge clk) begin
    cyc++;
    if (rx_done) begin
      checks++;
      if (done_prev) begin
        errors++;
        $display("FAIL done_adjacent: rx_done high on consecutive cycles at cyc %0d", cyc);
      end
      done_cnt++;
      prev_done_t = last_done_t;
      last_done_t = cyc;
    end
    done_prev = rx_done;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_clks,
                            output logic busy_mid);
    busy_mid = 1'b0;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT_CLKS / 2);
      if (i == 4) busy_mid = rx_busy;
      wait_clks(BIT_CLKS / 2);
    end
    rx = stop_v;
    wait_clks(stop_clks);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(3);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", rx_data); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", rx_done); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    rst = 1'b0;
    wait_clks(BIT_CLKS);
  endtask

  task automatic test_single;
    int n0;
    logic bm;
    n0 = done_cnt;
    send_frame(8'h30, 1'b1, BIT_CLKS, bm);
    wait_clks(BIT_CLKS);
    checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - n0); end
    checks++; if (rx_data !== 8'h30) begin errors++; $display("FAIL single_data: got %h want 30", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", frame_err); end
    checks++; if (bm !== 1'b1) begin errors++; $display("FAIL single_busy_mid: got %b want 1", bm); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int n0;
    logic bm;
    logic [7:0] d1;
    logic e1;
    n0 = done_cnt;
    send_frame(8'h55, 1'b1, BIT_CLKS, bm);
    d1 = rx_data;
    e1 = frame_err;
    send_frame(8'hA3, 1'b1, BIT_CLKS, bm);
    wait_clks(BIT_CLKS);
    checks++; if (d1 !== 8'h55) begin errors++; $display("FAIL b2b_data1: got %h want 55", d1); end
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL b2b_err1: got %b want 0", e1); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL b2b_data2: got %h want a3", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_err2: got %b want 0", frame_err); end
    checks++; if (done_cnt - n0 != 2) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 2", done_cnt - n0); end
    checks++;
    if ((last_done_t - prev_done_t < 10 * BIT_CLKS - TICK_DIV) ||
        (last_done_t - prev_done_t > 10 * BIT_CLKS + TICK_DIV)) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d clks want %0d", last_done_t - prev_done_t, 10 * BIT_CLKS);
    end
  endtask

  task automatic test_false_start;
    int n0;
    logic b;
    n0 = done_cnt;
    rx = 1'b0;
    wait_clks(3 * TICK_DIV);
    b  = rx_busy;
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL false_busy_mid: got %b want 1", b); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_busy_end: got %b want 0", rx_busy); end
    checks++; if (done_cnt != n0) begin errors++; $display("FAIL false_done_cnt: got %0d want 0", done_cnt - n0); end
    checks++; if (rx_data !== 8'hA3) begin errors++; $display("FAIL false_data: got %h want a3", rx_data); end
  endtask

  task automatic test_frame_err;
    int n0;
    logic bm;
    n0 = done_cnt;
    // Low stop released early enough that the re-entered start check sees idle.
    send_frame(8'h0F, 1'b0, BIT_CLKS * 3 / 4, bm);
    wait_clks(2 * BIT_CLKS);
    checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL ferr_done_cnt: got %0d want 1", done_cnt - n0); end
    checks++; if (rx_data !== 8'h0F) begin errors++; $display("FAIL ferr_data: got %h want 0f", rx_data); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b want 1", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy: got %b want 0", rx_busy); end
    n0 = done_cnt;
    send_frame(8'h81, 1'b1, BIT_CLKS, bm);
    wait_clks(BIT_CLKS);
    checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL ferr_next_cnt: got %0d want 1", done_cnt - n0); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h want 81", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid;
    int n0;
    logic b;
    logic bm;
    n0 = done_cnt;
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b1;
    wait_clks(4 * BIT_CLKS + BIT_CLKS / 2);
    b   = rx_busy;
    rst = 1'b1;
    #1;
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", b); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", rx_data); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", rx_busy); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", rx_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b want 0", frame_err); end
    wait_clks(2);
    rst = 1'b0;
    wait_clks(6 * BIT_CLKS);
    checks++; if (done_cnt != n0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - n0); end
    n0 = done_cnt;
    send_frame(8'h42, 1'b1, BIT_CLKS, bm);
    wait_clks(BIT_CLKS);
    checks++; if (done_cnt - n0 != 1) begin errors++; $display("FAIL rmid_next_cnt: got %0d want 1", done_cnt - n0); end
    checks++; if (rx_data !== 8'h42) begin errors++; $display("FAIL rmid_next_data: got %h want 42", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
